// File: rtl/seg_disp_pkg.sv
// Shared constants for the seven-segment scan driver: glyph table, blank code
// and the select-width helper.
package seg_disp_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Active-low a..g patterns for hex glyphs 0..F
  localparam logic [6:0] SEG7_TABLE [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  function automatic int calc_wsel(input int digits);
    int w;
    w = $clog2(digits);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational nibble-to-segment decoder for common-anode digits; the dp
// segment is independent of blanking.
module hex_to_seg7
  import seg_disp_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  input  logic       dp,
  output logic [7:0] seg
);

  assign seg = {(blank ? SEG_BLANK : SEG7_TABLE[nibble]), ~dp};

endmodule

// File: rtl/seg_scan_display.sv
// Multiplexed seven-segment scanner with double-buffered frame loading,
// leading-zero suppression and 16-level brightness PWM.
module seg_scan_display
  import seg_disp_pkg::*;
#(
  parameter  int DIGITS   = 8,
  parameter  int DIV_BITS = 11,
  localparam int WSEL     = calc_wsel(DIGITS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   load_data,
  input  logic [DIGITS-1:0]     load_dp,
  input  logic [DIGITS-1:0]     load_blank,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic                  lzs_en,
  input  logic [3:0]            bright,
  output logic [WSEL-1:0]       which,
  output logic [7:0]            seg,
  output logic                  enable,
  output logic                  frame_done
);

  logic [DIV_BITS-1:0]  cnt, cnt_nxt;
  logic [4*DIGITS-1:0]  disp_data, pend_data;
  logic [DIGITS-1:0]    disp_dp, disp_blank, pend_dp, pend_blank;
  logic                 slot_end, wrap, xfer, en_nxt;
  logic [3:0]           nib;
  logic                 dig_dp, dig_blank, lead_zero;
  logic [7:0]           seg_p0;

  assign cnt_nxt  = cnt + 1'b1;
  assign slot_end = &cnt;
  assign wrap     = slot_end && (which == WSEL'(DIGITS - 1));
  assign xfer     = load_valid && load_ready;
  // Enable tracks the cnt value it is shown with; cnt==0 is the stale-seg cycle
  assign en_nxt   = (cnt_nxt != '0) && (cnt_nxt[DIV_BITS-1 -: 4] <= bright);

  // Stage p0: pick the driven digit and resolve blanking
  always_comb begin
    nib       = '0;
    dig_dp    = 1'b0;
    dig_blank = 1'b0;
    lead_zero = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      lead_zero = lead_zero && (disp_data[4*(DIGITS-i)-1 -: 4] == 4'd0);
      if (which == WSEL'(i)) begin
        nib       = disp_data[4*(DIGITS-i)-1 -: 4];
        dig_dp    = disp_dp[DIGITS-1-i];
        dig_blank = disp_blank[DIGITS-1-i] || (lzs_en && lead_zero && (i < DIGITS - 1));
      end
    end
  end

  hex_to_seg7 u_dec (
    .nibble (nib),
    .blank  (dig_blank),
    .dp     (dig_dp),
    .seg    (seg_p0)
  );

  // Stage p1: scan counters, handshake, frame buffers and registered pins
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt        <= '0;
      which      <= '0;
      seg        <= 8'hFF;
      enable     <= 1'b0;
      frame_done <= 1'b0;
      load_ready <= 1'b1;
      disp_data  <= '0;
      disp_dp    <= '0;
      disp_blank <= '0;
    end else begin
      cnt        <= cnt_nxt;
      seg        <= seg_p0;
      enable     <= en_nxt;
      frame_done <= wrap;
      if (slot_end)
        which <= wrap ? '0 : which + 1'b1;
      if (xfer && wrap) begin
        // Data arriving on the frame boundary bypasses the pending buffer
        disp_data  <= load_data;
        disp_dp    <= load_dp;
        disp_blank <= load_blank;
      end else if (xfer) begin
        load_ready <= 1'b0;
      end else if (wrap && !load_ready) begin
        disp_data  <= pend_data;
        disp_dp    <= pend_dp;
        disp_blank <= pend_blank;
        load_ready <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (xfer && !wrap) begin
      pend_data  <= load_data;
      pend_dp    <= load_dp;
      pend_blank <= load_blank;
    end
  end

endmodule

// File: tb/tb_seg_scan_display.sv
// Randomised bench for seg_scan_display against a slot/frame arithmetic model.
module tb_seg_scan_display;

  localparam int DIGITS   = 8;
  localparam int DIV_BITS = 5;
  localparam int SLOT     = 1 << DIV_BITS;
  localparam logic [7:0] SEGTAB [16] = '{
    8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
    8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71
  };

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] load_data;
  logic [7:0]  load_dp, load_blank;
  logic        load_valid, load_ready, lzs_en;
  logic [3:0]  bright;
  logic [2:0]  which;
  logic [7:0]  seg;
  logic        enable, frame_done;

  int n_checks = 0;
  int n_fail   = 0;

  // model state
  int          m_t;
  logic [31:0] m_data, p_data;
  logic [7:0]  m_dp, m_blank, p_dp, p_blank, m_seg;
  logic        m_ready, m_en, m_fd;

  seg_scan_display #(.DIGITS(DIGITS), .DIV_BITS(DIV_BITS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_data  (load_data),
    .load_dp    (load_dp),
    .load_blank (load_blank),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .lzs_en     (lzs_en),
    .bright     (bright),
    .which      (which),
    .seg        (seg),
    .enable     (enable),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0d)", tag, got, exp, m_t);
    end
  endtask

  function automatic logic [7:0] ref_seg(input int w);
    logic [31:0] head;
    logic        blank;
    logic        dp;
    head  = m_data >> (4 * (DIGITS - 1 - w));
    dp    = m_dp[DIGITS-1-w];
    blank = m_blank[DIGITS-1-w] || (lzs_en && head == 32'd0 && w < DIGITS - 1);
    return (blank ? 8'hFE : (SEGTAB[head[3:0]] & 8'hFE)) | {7'd0, ~dp};
  endfunction

  task automatic model_edge();
    int  c, w;
    bit  wrap, xfer;
    if (!rst_n) begin
      m_t = 0; m_data = '0; m_dp = '0; m_blank = '0;
      m_ready = 1'b1; m_seg = 8'hFF; m_en = 1'b0; m_fd = 1'b0;
      return;
    end
    c    = m_t % SLOT;
    w    = (m_t / SLOT) % DIGITS;
    wrap = (c == SLOT - 1) && (w == DIGITS - 1);
    xfer = load_valid && m_ready;
    m_seg = ref_seg(w);
    c    = (m_t + 1) % SLOT;
    m_en = (c != 0) && ((c >> (DIV_BITS - 4)) <= int'(bright));
    m_fd = wrap;
    if (xfer && wrap) begin
      m_data = load_data; m_dp = load_dp; m_blank = load_blank;
    end else if (xfer) begin
      p_data = load_data; p_dp = load_dp; p_blank = load_blank; m_ready = 1'b0;
    end else if (wrap && !m_ready) begin
      m_data = p_data; m_dp = p_dp; m_blank = p_blank; m_ready = 1'b1;
    end
    m_t++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("which", 32'(which), 32'((m_t / SLOT) % DIGITS));
    chk("seg", 32'(seg), 32'(m_seg));
    chk("enable", 32'(enable), 32'(m_en));
    chk("frame_done", 32'(frame_done), 32'(m_fd));
    chk("load_ready", 32'(load_ready), 32'(m_ready));
  endtask

  task automatic wait_fd(input int max);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!frame_done && n < max);
    chk("fd_wait", 32'(frame_done), 32'd1);
  endtask

  task automatic offer(input logic [31:0] d, input logic [7:0] dp, input logic [7:0] bl,
                       output logic fd_seen);
    logic acc;
    acc = 1'b0;
    fd_seen = 1'b0;
    load_data = d; load_dp = dp; load_blank = bl; load_valid = 1'b1;
    for (int n = 0; n < 600 && !acc; n++) begin
      acc = load_ready;
      fd_seen = frame_done;
      tick();
    end
    load_valid = 1'b0;
    chk("offer_acc", 32'(acc), 32'd1);
  endtask

  task automatic check_frame(input string tag, input logic [7:0] exp [8]);
    for (int s = 0; s < DIGITS; s++) begin
      repeat (SLOT / 2) tick();
      chk(tag, 32'(seg), 32'(exp[s]));
      repeat (SLOT / 2) tick();
    end
  endtask

  initial begin
    logic        fd;
    int          cnt;
    logic [7:0]  exp [8];
    int          blev [3];
    int          bexp [3];

    rst_n = 1'b0; load_data = '0; load_dp = '0; load_blank = '0;
    load_valid = 1'b0; lzs_en = 1'b0; bright = 4'd15;
    m_t = 0; p_data = '0; p_dp = '0; p_blank = '0;
    tick(); tick();
    rst_n = 1'b1;
    chk("rst_which", 32'(which), 32'd0);
    chk("rst_seg", 32'(seg), 32'hFF);
    chk("rst_enable", 32'(enable), 32'd0);
    chk("rst_ready", 32'(load_ready), 32'd1);

    // basic load: shows only after the next wrap
    offer(32'h1234ABCD, 8'h00, 8'h00, fd);
    chk("s1_old_digit0", 32'(seg), 32'h03);
    wait_fd(300);
    exp = '{8'h9F, 8'h25, 8'h0D, 8'h99, 8'h11, 8'hC1, 8'h63, 8'h85};
    check_frame("s1_seg", exp);
    cnt = 0;
    for (int i = 0; i < 8 * 64; i++) begin
      tick();
      cnt += int'(frame_done);
    end
    chk("s1_fd_count", 32'(cnt), 32'd2);

    // tear-free: second word waits for the wrap
    repeat (100) tick();
    offer(32'h0000_0005, 8'h00, 8'h00, fd);
    offer(32'hDEAD_BEEF, 8'h00, 8'h00, fd);
    chk("s2_acc_at_wrap", 32'(fd), 32'd1);
    repeat (239) tick();
    chk("s2_digit7", 32'(seg), 32'h49);
    wait_fd(300);

    // leading-zero suppression
    lzs_en = 1'b1;
    offer(32'h0000_0000, 8'h00, 8'h00, fd);
    wait_fd(300);
    exp = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h03};
    check_frame("s3_lzs_zero", exp);
    offer(32'h0010_0000, 8'h00, 8'h00, fd);
    wait_fd(300);
    exp = '{8'hFF, 8'hFF, 8'h9F, 8'h03, 8'h03, 8'h03, 8'h03, 8'h03};
    check_frame("s3_lzs_one", exp);

    // dp and forced blank
    lzs_en = 1'b0;
    offer(32'h8888_8888, 8'b0000_0100, 8'b1000_0000, fd);
    wait_fd(300);
    exp = '{8'hFF, 8'h01, 8'h01, 8'h01, 8'h01, 8'h00, 8'h01, 8'h01};
    check_frame("s4_dp_blank", exp);

    // brightness: enable-high cycles per slot
    blev = '{0, 7, 15};
    bexp = '{1, 15, 31};
    for (int b = 0; b < 3; b++) begin
      bright = 4'(blev[b]);
      cnt = 0;
      for (int i = 0; i < SLOT; i++) begin
        tick();
        cnt += int'(enable);
      end
      chk("s5_bright", 32'(cnt), 32'(bexp[b]));
    end

    // randomised traffic
    for (int i = 0; i < 3000; i++) begin
      load_valid = ($urandom_range(0, 7) == 0);
      load_data  = $urandom();
      load_dp    = 8'($urandom_range(0, 255));
      load_blank = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 63) == 0) lzs_en = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 63) == 0) bright = 4'($urandom_range(0, 15));
      tick();
    end
    load_valid = 1'b0;

    // reset mid-frame with pending data
    lzs_en = 1'b0; bright = 4'd15;
    wait_fd(600);
    wait_fd(600);
    offer(32'h9876_5432, 8'hFF, 8'h00, fd);
    chk("s7_pend_full", 32'(load_ready), 32'd0);
    cnt = 0;
    while (which != 3'd5 && cnt < 400) begin
      tick();
      cnt++;
    end
    chk("s7_reach5", 32'(which), 32'd5);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("s7_which", 32'(which), 32'd0);
    chk("s7_seg", 32'(seg), 32'hFF);
    chk("s7_enable", 32'(enable), 32'd0);
    chk("s7_ready", 32'(load_ready), 32'd1);
    repeat (SLOT / 2) tick();
    chk("s7_zero_disp", 32'(seg), 32'h03);
    wait_fd(300);
    repeat (SLOT / 2) tick();
    chk("s7_no_pending", 32'(seg), 32'h03);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
